// File: rtl/missile_pkg.sv
// missile_pkg
//   Shared types and constants for the missile launcher/motion block, the
//   explosion controller and the sprite/colour mapper.
//   - missile_state_t : launcher FSM states
//   - GROUND_Y_DEF    : Y at which a flight ends (also the controller threshold)
//   - SCREEN_W/H      : visible screen size in pixels
//   - vel_next()      : saturating velocity increment used by the gravity build
package missile_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    FLY   = 3'd2,
    BLAST = 3'd3,
    COOL  = 3'd4
  } missile_state_t;

  localparam logic [9:0] GROUND_Y_DEF     = 10'd390;
  localparam logic [3:0] FALL_STEP_DEF    = 4'd4;
  localparam logic [3:0] MAX_VEL_DEF      = 4'd12;
  localparam logic [2:0] BLAST_FRAMES_DEF = 3'd6;
  localparam logic [3:0] ARM_TIMEOUT_DEF  = 4'd8;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Increment velocity by one pixel/frame, never exceeding the ceiling.
  function automatic logic [3:0] vel_next(input logic [3:0] vel,
                                          input logic [3:0] max_vel);
    vel_next = (vel >= max_vel) ? max_vel : vel + 4'd1;
  endfunction

endpackage

// File: rtl/frame_tick_detect.sv
// frame_tick_detect
//   Brings an asynchronous frame clock (vertical sync) into the Clk domain
//   with a two-flop synchroniser and emits a one-Clk pulse on each
//   synchronised rising edge. Reusable by any sprite block that steps once
//   per frame.
// Ports
//   clk       in  1  system clock
//   rst_n     in  1  asynchronous active-low reset
//   async_in  in  1  asynchronous frame clock
//   tick      out 1  one-cycle pulse per rising edge of async_in
module frame_tick_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic tick
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= async_in;
      // synchroniser output stage
      sync_p1 <= sync_p0;
      // edge-detect history stage
      prev_p2 <= sync_p1;
    end
  end

  assign tick = sync_p1 & ~prev_p2;

endmodule

// File: rtl/missile_motion.sv
// missile_motion
//   Launcher/motion end of the missile interface. A fire request spawns a
//   missile at the player position and raises launch towards the explosion
//   controller. Once the controller reports the missile in flight (explored
//   low) the missile drops a fixed step per frame until it reaches the ground,
//   then a fixed-length blast animation plays and the launcher rearms once
//   fire is released.
// Configuration
//   MISSILE_GRAVITY_EN : when defined, velocity grows by one pixel/frame after
//                        every flight step, capped at MAX_VEL.
// Ports
//   Clk           in  1   system clock
//   Reset_n       in  1   asynchronous active-low reset
//   frame_clk     in  1   asynchronous frame clock, rising edge = one frame
//   fire          in  1   level fire request
//   launch_X      in  10  spawn X
//   launch_Y      in  10  spawn Y
//   explored      in  1   controller status, 0 = missile in flight
//   launch        out 1   launch request to the explosion controller
//   missile_X_Pos out 10  missile X, held for the whole flight
//   missile_Y_Pos out 10  missile Y
//   missile_on    out 1   missile sprite visible
//   blast_on      out 1   blast sprite visible
//   blast_frame   out 3   blast animation index
//   busy          out 1   launcher not idle
module missile_motion
  import missile_pkg::*;
#(
  parameter logic [9:0] GROUND_Y     = GROUND_Y_DEF,
  parameter logic [3:0] FALL_STEP    = FALL_STEP_DEF,
  parameter logic [3:0] MAX_VEL      = MAX_VEL_DEF,
  parameter logic [2:0] BLAST_FRAMES = BLAST_FRAMES_DEF,
  parameter logic [3:0] ARM_TIMEOUT  = ARM_TIMEOUT_DEF
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [9:0] launch_X,
  input  logic [9:0] launch_Y,
  input  logic       explored,
  output logic       launch,
  output logic [9:0] missile_X_Pos,
  output logic [9:0] missile_Y_Pos,
  output logic       missile_on,
  output logic       blast_on,
  output logic [2:0] blast_frame,
  output logic       busy
);

`ifdef MISSILE_GRAVITY_EN
  localparam bit GRAVITY = 1'b1;
`else
  localparam bit GRAVITY = 1'b0;
`endif

  missile_state_t state, state_nxt;
  logic [9:0]  x_q, x_nxt;
  logic [9:0]  y_q, y_nxt;
  logic [3:0]  vel_q, vel_nxt;
  logic [3:0]  arm_cnt_q, arm_cnt_nxt;
  logic [2:0]  bf_q, bf_nxt;
  logic        frame_tick;
  logic [10:0] sum;
  logic        ground;
  logic [3:0]  vel_upd;

  frame_tick_detect u_tick (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .async_in (frame_clk),
    .tick     (frame_tick)
  );

  // 11-bit sum so a spawn near the bottom of the 10-bit range cannot wrap
  // back above the ground line.
  assign sum     = {1'b0, y_q} + {7'd0, vel_q};
  assign ground  = (sum >= {1'b0, GROUND_Y});
  assign vel_upd = GRAVITY ? vel_next(vel_q, MAX_VEL) : vel_q;

  always_comb begin
    state_nxt   = state;
    x_nxt       = x_q;
    y_nxt       = y_q;
    vel_nxt     = vel_q;
    arm_cnt_nxt = arm_cnt_q;
    bf_nxt      = bf_q;
    unique case (state)
      IDLE: begin
        if (fire) begin
          x_nxt       = launch_X;
          y_nxt       = launch_Y;
          vel_nxt     = FALL_STEP;
          arm_cnt_nxt = 4'd0;
          state_nxt   = ARM;
        end
      end
      ARM: begin
        // Frame ticks are ignored here; only the controller handshake matters.
        if (!explored) begin
          state_nxt = FLY;
        end else if (arm_cnt_q == ARM_TIMEOUT - 4'd1) begin
          state_nxt = IDLE;
        end else begin
          arm_cnt_nxt = arm_cnt_q + 4'd1;
        end
      end
      FLY: begin
        // Reaching the ground wins over an external abort in the same cycle.
        if (frame_tick && ground) begin
          y_nxt     = GROUND_Y;
          vel_nxt   = vel_upd;
          bf_nxt    = 3'd0;
          state_nxt = BLAST;
        end else if (explored) begin
          bf_nxt    = 3'd0;
          state_nxt = BLAST;
        end else if (frame_tick) begin
          y_nxt   = sum[9:0];
          vel_nxt = vel_upd;
        end
      end
      BLAST: begin
        if (frame_tick) begin
          if (bf_q == BLAST_FRAMES - 3'd1) begin
            bf_nxt    = 3'd0;
            state_nxt = COOL;
          end else begin
            bf_nxt = bf_q + 3'd1;
          end
        end
      end
      COOL: begin
        // Waiting for fire to drop prevents a held key from auto-refiring.
        if (!fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      x_q       <= 10'd0;
      y_q       <= 10'd0;
      vel_q     <= 4'd0;
      arm_cnt_q <= 4'd0;
      bf_q      <= 3'd0;
    end else begin
      state     <= state_nxt;
      x_q       <= x_nxt;
      y_q       <= y_nxt;
      vel_q     <= vel_nxt;
      arm_cnt_q <= arm_cnt_nxt;
      bf_q      <= bf_nxt;
    end
  end

  // Outputs decode only registered state, so they are glitch-free.
  assign launch        = (state == ARM);
  assign missile_on    = (state == FLY);
  assign blast_on      = (state == BLAST);
  assign busy          = (state != IDLE);
  assign blast_frame   = bf_q;
  assign missile_X_Pos = x_q;
  assign missile_Y_Pos = y_q;

endmodule

// File: tb/tb_missile_motion.sv
module tb_missile_motion;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       fire = 1'b0;
  logic [9:0] launch_X = 10'd0;
  logic [9:0] launch_Y = 10'd0;
  logic       explored = 1'b1;
  logic       launch;
  logic [9:0] missile_X_Pos;
  logic [9:0] missile_Y_Pos;
  logic       missile_on;
  logic       blast_on;
  logic [2:0] blast_frame;
  logic       busy;

  missile_motion dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_clk     (frame_clk),
    .fire          (fire),
    .launch_X      (launch_X),
    .launch_Y      (launch_Y),
    .explored      (explored),
    .launch        (launch),
    .missile_X_Pos (missile_X_Pos),
    .missile_Y_Pos (missile_Y_Pos),
    .missile_on    (missile_on),
    .blast_on      (blast_on),
    .blast_frame   (blast_frame),
    .busy          (busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int mdl_y;
  int mdl_vel;

  typedef struct {
    int lx;
    int ly;
    bit respond;
    int exp_launch;
    bit exp_fly;
  } shot_t;

  shot_t shots[5];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Called at a negedge; returns at a negedge after the tick has been consumed.
  task automatic pulse_frame();
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic fly_tick(output bit grounded);
    int s;
    int e;
    s = mdl_y + mdl_vel;
    grounded = 1'b0;
    if (s >= 390) begin
      mdl_y = 390;
      grounded = 1'b1;
    end else begin
      mdl_y = s;
    end
`ifdef MISSILE_GRAVITY_EN
    if (mdl_vel < 12) mdl_vel++;
`endif
    exp_q.push_back(mdl_y);
    pulse_frame();
    e = exp_q.pop_front();
    check("y_step", int'(missile_Y_Pos), e);
  endtask

  task automatic do_fire(input bit hold, input bit respond, output int lcnt);
    lcnt = 0;
    fire = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (!hold) fire = 1'b0;
      if (launch) begin
        lcnt++;
        if (respond) explored = 1'b0;
      end else if (lcnt > 0) begin
        break;
      end
    end
  endtask

  task automatic fly_to_ground(input int max_frames);
    bit g;
    int frames;
    g = 1'b0;
    frames = 0;
    while (!g && frames < max_frames) begin
      fly_tick(g);
      frames++;
      if (!g) check("missile_on_fly", int'(missile_on), 1);
    end
    check("ground_reached", int'(g), 1);
    check("blast_on_ground", int'(blast_on), 1);
    check("missile_off_ground", int'(missile_on), 0);
    explored = 1'b1;
  endtask

  task automatic run_blast();
    for (int f = 0; f < 6; f++) begin
      check("blast_on_anim", int'(blast_on), 1);
      check("blast_frame", int'(blast_frame), f);
      pulse_frame();
    end
    check("blast_off_after", int'(blast_on), 0);
    check("blast_frame_after", int'(blast_frame), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc;
    int lcount;
    bit g;
    int grav_exp[10];

    shots[0] = '{lx: 320,  ly: 100, respond: 1'b1, exp_launch: 1, exp_fly: 1'b1};
    shots[1] = '{lx: 17,   ly: 380, respond: 1'b1, exp_launch: 1, exp_fly: 1'b1};
    shots[2] = '{lx: 5,    ly: 400, respond: 1'b1, exp_launch: 1, exp_fly: 1'b1};
    shots[3] = '{lx: 600,  ly: 0,   respond: 1'b0, exp_launch: 8, exp_fly: 1'b0};
    shots[4] = '{lx: 1023, ly: 389, respond: 1'b1, exp_launch: 1, exp_fly: 1'b1};

    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_launch", int'(launch), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_y", int'(missile_Y_Pos), 0);
    check("rst_x", int'(missile_X_Pos), 0);
    check("rst_blast_frame", int'(blast_frame), 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Table-driven shots
    for (int k = 0; k < 5; k++) begin
      launch_X = 10'(shots[k].lx);
      launch_Y = 10'(shots[k].ly);
      mdl_y = shots[k].ly;
      mdl_vel = 4;
      do_fire(1'b0, shots[k].respond, lc);
      check("launch_cycles", lc, shots[k].exp_launch);
      check("busy_after_arm", int'(busy), int'(shots[k].exp_fly));
      check("missile_on_after_arm", int'(missile_on), int'(shots[k].exp_fly));
      if (shots[k].exp_fly) begin
        check("spawn_x", int'(missile_X_Pos), shots[k].lx);
        check("spawn_y", int'(missile_Y_Pos), shots[k].ly);
        fly_to_ground(200);
        check("x_held", int'(missile_X_Pos), shots[k].lx);
        run_blast();
        check("idle_after_cool", int'(busy), 0);
      end
      explored = 1'b1;
      repeat (2) @(negedge Clk);
    end

    // Reset asserted mid-flight
    launch_X = 10'd50;
    launch_Y = 10'd100;
    mdl_y = 100;
    mdl_vel = 4;
    do_fire(1'b0, 1'b1, lc);
    check("rstmid_launch_cycles", lc, 1);
    for (int t = 0; t < 25; t++) fly_tick(g);
`ifndef MISSILE_GRAVITY_EN
    check("rstmid_y_before", int'(missile_Y_Pos), 200);
`endif
    Reset_n = 1'b0;
    #1;
    check("rstmid_launch", int'(launch), 0);
    check("rstmid_missile_on", int'(missile_on), 0);
    check("rstmid_blast_on", int'(blast_on), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_y", int'(missile_Y_Pos), 0);
    check("rstmid_x", int'(missile_X_Pos), 0);
    repeat (2) @(negedge Clk);
    explored = 1'b1;
    Reset_n = 1'b1;
    lcount = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge Clk);
      if (launch || busy) lcount++;
    end
    check("rstmid_stays_idle", lcount, 0);

    // External abort just above ground
    launch_X = 10'd200;
    launch_Y = 10'd372;
    mdl_y = 372;
    mdl_vel = 4;
    do_fire(1'b0, 1'b1, lc);
    check("abort_launch_cycles", lc, 1);
    fly_tick(g);
    fly_tick(g);
    check("abort_y_before", int'(missile_Y_Pos), mdl_y);
    explored = 1'b1;
    @(negedge Clk);
    check("abort_blast_on", int'(blast_on), 1);
    check("abort_missile_on", int'(missile_on), 0);
    check("abort_y_held", int'(missile_Y_Pos), mdl_y);
    run_blast();
    check("abort_idle", int'(busy), 0);

    // Fire held through a whole shot: exactly one launch
    launch_X = 10'd400;
    launch_Y = 10'd300;
    mdl_y = 300;
    mdl_vel = 4;
    do_fire(1'b1, 1'b1, lc);
    check("held_launch_cycles", lc, 1);
    fly_to_ground(200);
    run_blast();
    check("held_cool_busy", int'(busy), 1);
    check("held_cool_missile_on", int'(missile_on), 0);
    lcount = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge Clk);
      if (launch) lcount++;
    end
    check("held_no_refire", lcount, 0);
    check("held_still_cool", int'(busy), 1);
    fire = 1'b0;
    repeat (2) @(negedge Clk);
    check("held_release_idle", int'(busy), 0);
    lcount = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge Clk);
      if (launch) lcount++;
    end
    check("held_release_no_launch", lcount, 0);

`ifdef MISSILE_GRAVITY_EN
    // Gravity profile from Y=0
    grav_exp = '{4, 9, 15, 22, 30, 39, 49, 60, 72, 84};
    launch_X = 10'd10;
    launch_Y = 10'd0;
    mdl_y = 0;
    mdl_vel = 4;
    do_fire(1'b0, 1'b1, lc);
    check("grav_launch_cycles", lc, 1);
    for (int t = 0; t < 10; t++) begin
      fly_tick(g);
      check("grav_y_profile", int'(missile_Y_Pos), grav_exp[t]);
    end
    fly_to_ground(200);
    run_blast();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
